// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl
// Control-flow sequencer for the pipelined core. Resolves EX-stage branches
// and jumps from the ALU zero/less flags, issues a PC redirect to fetch over a
// valid/ready handshake, squashes the IF/ID and ID/EX registers around the
// redirect, and inserts a one-cycle bubble for load-use hazards.
//
// Handshake: redirect_valid rises with redirect_pc and both stay stable until
// the cycle in which redirect_valid & redirect_ready are both high. That cycle
// is the transfer, and redirect_valid drops on the following cycle.
//
// Optional build macro: BRANCH_PERF_CNT_EN adds three 32-bit performance
// counters (taken resolutions, flush cycles, load-use bubble cycles).
module branch_redirect_ctrl #(
   parameter int ADDR_W       = 32,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ex_valid,
   input  logic              ex_beq,
   input  logic              ex_bne,
   input  logic              ex_blt,
   input  logic              ex_bge,
   input  logic              ex_ble,
   input  logic              ex_jal,
   input  logic              zero,
   input  logic              less,
   input  logic [ADDR_W-1:0] ex_target,
   input  logic              pipe_stall,
   input  logic              ld_use_hazard,
   input  logic              redirect_ready,
   output logic              redirect_valid,
   output logic [ADDR_W-1:0] redirect_pc,
   output logic              flush_if_id,
   output logic              flush_id_ex,
   output logic              stall_pc,
   output logic              stall_if_id,
   output logic              bubble_id_ex,
   output logic              busy
`ifdef BRANCH_PERF_CNT_EN
   ,
   output logic [31:0]       perf_taken_cnt,
   output logic [31:0]       perf_flush_cnt,
   output logic [31:0]       perf_ldstall_cnt
`endif
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REDIRECT = 2'd1,
      SQUASH   = 2'd2
   } state_t;

   // Remaining squash cycles after the redirect transfer.
   localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);

   state_t     state;
   logic [3:0] flush_cnt;
   logic       taken;
   logic       taken_resolved;

   // Branch decision; a memory stall freezes evaluation entirely.
   always_comb begin
      taken = ex_valid & ~pipe_stall &
              ((ex_beq & zero) |
               (ex_bne & ~zero) |
               (ex_blt & less) |
               (ex_bge & (zero | ~less)) |
               (ex_ble & (zero | less)) |
               ex_jal);
      // Only IDLE acts on a branch; later ones are wrong-path instructions.
      taken_resolved = (state == IDLE) & taken;
   end

   // Controller FSM with all outputs registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         flush_cnt      <= '0;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
         flush_if_id    <= 1'b0;
         flush_id_ex    <= 1'b0;
         stall_pc       <= 1'b0;
         stall_if_id    <= 1'b0;
         bubble_id_ex   <= 1'b0;
         busy           <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               redirect_valid <= 1'b0;
               flush_if_id    <= 1'b0;
               flush_id_ex    <= 1'b0;
               stall_pc       <= 1'b0;
               stall_if_id    <= 1'b0;
               bubble_id_ex   <= 1'b0;
               busy           <= 1'b0;
               if (taken) begin
                  // The redirect wins; a coincident hazard is on the wrong path.
                  state          <= REDIRECT;
                  redirect_valid <= 1'b1;
                  redirect_pc    <= ex_target;
                  flush_if_id    <= 1'b1;
                  flush_id_ex    <= 1'b1;
                  busy           <= 1'b1;
               end else if (ld_use_hazard && !pipe_stall) begin
                  stall_pc     <= 1'b1;
                  stall_if_id  <= 1'b1;
                  bubble_id_ex <= 1'b1;
               end
            end
            REDIRECT: begin
               stall_pc     <= 1'b0;
               stall_if_id  <= 1'b0;
               bubble_id_ex <= 1'b0;
               if (redirect_valid && redirect_ready) begin
                  redirect_valid <= 1'b0;
                  if (FLUSH_CYCLES == 1) begin
                     state       <= IDLE;
                     flush_if_id <= 1'b0;
                     flush_id_ex <= 1'b0;
                     busy        <= 1'b0;
                  end else begin
                     state     <= SQUASH;
                     flush_cnt <= FLUSH_RELOAD;
                  end
               end
            end
            SQUASH: begin
               if (flush_cnt <= 4'd1) begin
                  state       <= IDLE;
                  flush_cnt   <= '0;
                  flush_if_id <= 1'b0;
                  flush_id_ex <= 1'b0;
                  busy        <= 1'b0;
               end else begin
                  flush_cnt <= flush_cnt - 4'd1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef BRANCH_PERF_CNT_EN
   // Free-running event counters, wrapping modulo 2^32.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_taken_cnt   <= '0;
         perf_flush_cnt   <= '0;
         perf_ldstall_cnt <= '0;
      end else begin
         if (taken_resolved)             perf_taken_cnt   <= perf_taken_cnt + 32'd1;
         if (flush_if_id || flush_id_ex) perf_flush_cnt   <= perf_flush_cnt + 32'd1;
         if (bubble_id_ex)               perf_ldstall_cnt <= perf_ldstall_cnt + 32'd1;
      end
   end
`else
   // Without counters the resolved-taken strobe has no consumer.
   logic unused_taken;
   always_comb unused_taken = taken_resolved;
`endif

endmodule
